// File: rtl/memory_pkg.sv
// Shared memory-subsystem definitions used by the D1 request arbiter.
package memory_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } d1_arb_state_t;

    localparam int D1_ARB_N = 4;

endpackage

// File: rtl/onehot_enc.sv
// Non-priority one-hot to binary encoder: ORs the indices of all set bits,
// so the input must carry at most one set bit for a meaningful result.
module onehot_enc #(
    parameter int D = 4,
    parameter int E = 2
) (
    input  logic [D-1:0] d_i,
    output logic [E-1:0] e_o
);

    // OR together the index of every asserted input bit
    always_comb begin
        e_o = {E{1'b0}};
        for (int i = 0; i < D; i++) begin
            e_o = e_o | (E'(i) & {E{d_i[i]}});
        end
    end

endmodule

// File: rtl/d1_req_arbiter.sv
// Round-robin arbiter sharing the D1 data-cache request port among N requesters.
// One registered grant at a time, held until the cache accepts it.
module d1_req_arbiter
    import memory_pkg::*;
#(
    parameter int N     = D1_ARB_N,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    input  logic             gnt_ready_i,
    output logic [IDX_W-1:0] prio_ptr_o
);

    d1_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             handshake_s;
    logic [IDX_W-1:0] ptr_inc_s;
    logic [IDX_W-1:0] sel_ptr_s;
    logic [N-1:0]     served_oh_s;
    logic [N-1:0]     sel_vec_s;
    logic [N-1:0]     hi_s;
    logic [N-1:0]     hi_low_s;
    logic [N-1:0]     all_low_s;
    logic [IDX_W-1:0] hi_idx_s;
    logic [IDX_W-1:0] all_idx_s;
    logic [IDX_W-1:0] sel_idx_s;

    assign handshake_s = (state_q == GRANT) && gnt_ready_i;

    // Pointer after serving gnt_idx_q; wraps explicitly so non-power-of-2 N works
    always_comb begin
        if (gnt_idx_q == IDX_W'(N - 1)) begin
            ptr_inc_s = {IDX_W{1'b0}};
        end else begin
            ptr_inc_s = gnt_idx_q + IDX_W'(1);
        end
    end

    // On a handshake the served requester is excluded and the advanced pointer is used
    always_comb begin
        sel_ptr_s = handshake_s ? ptr_inc_s : ptr_q;
        for (int i = 0; i < N; i++) begin
            served_oh_s[i] = (gnt_idx_q == IDX_W'(i));
        end
        sel_vec_s = handshake_s ? (req_valid_i & ~served_oh_s) : req_valid_i;
        for (int i = 0; i < N; i++) begin
            hi_s[i] = sel_vec_s[i] && (IDX_W'(i) >= sel_ptr_s);
        end
    end

    // Isolate the lowest set bit so the non-priority encoder sees a one-hot vector
    assign hi_low_s  = hi_s & (~hi_s + N'(1));
    assign all_low_s = sel_vec_s & (~sel_vec_s + N'(1));

    onehot_enc #(.D(N), .E(IDX_W)) u_enc_hi (
        .d_i (hi_low_s),
        .e_o (hi_idx_s)
    );

    onehot_enc #(.D(N), .E(IDX_W)) u_enc_all (
        .d_i (all_low_s),
        .e_o (all_idx_s)
    );

    assign sel_idx_s = (|hi_s) ? hi_idx_s : all_idx_s;

    // Next-state logic for the grant FSM
    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d   = GRANT;
                    gnt_idx_d = sel_idx_s;
                end else begin
                    state_d   = IDLE;
                end
            end
            GRANT: begin
                if (gnt_ready_i) begin
                    ptr_d = ptr_inc_s;
                    if (|sel_vec_s) begin
                        gnt_idx_d = sel_idx_s;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant index and priority pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_idx_q <= {IDX_W{1'b0}};
            ptr_q     <= {IDX_W{1'b0}};
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    // Accept strobe goes only to the granted requester, straight from the cache ready
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready_o[i] = handshake_s && served_oh_s[i];
        end
    end

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = gnt_idx_q;
    assign prio_ptr_o  = ptr_q;

endmodule

// File: tb/tb_d1_req_arbiter.sv
// Directed, table-driven bench for d1_req_arbiter (N=4) with hand-written stall sequence.
module tb_d1_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       gnt_ready;
    logic [1:0] prio_ptr;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic       valid;
        logic [1:0] idx;
        logic       chk_idx;
        logic [1:0] ptr;
        logic [3:0] ready;
    } vec_t;

    vec_t vecs[$];

    d1_req_arbiter #(.N(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .gnt_ready_i (gnt_ready),
        .prio_ptr_o  (prio_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A granted requester must keep its valid up until it is accepted
    always @(posedge clk) begin
        if (rst_n && gnt_valid) begin
            assert (req_valid[gnt_idx])
            else $error("protocol: requester %0d withdrew valid while granted", gnt_idx);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic rd, input logic v,
                       input logic [1:0] ix, input logic ci, input logic [1:0] p,
                       input logic [3:0] rdy_o);
        vec_t t;
        t = '{rst_n: r, req: rq, rdy: rd, valid: v, idx: ix, chk_idx: ci, ptr: p, ready: rdy_o};
        vecs.push_back(t);
    endtask

    task automatic obs(input string tag, input logic v, input logic [1:0] ix, input logic ci,
                       input logic [1:0] p, input logic [3:0] rdy_o);
        chk({tag, ".gnt_valid"}, {31'd0, gnt_valid}, {31'd0, v});
        if (ci) chk({tag, ".gnt_idx"}, {30'd0, gnt_idx}, {30'd0, ix});
        chk({tag, ".prio_ptr"}, {30'd0, prio_ptr}, {30'd0, p});
        chk({tag, ".req_ready"}, {28'd0, req_ready}, {28'd0, rdy_o});
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        gnt_ready = 1'b0;

        // reset, then idle for five cycles
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        for (int i = 0; i < 5; i++) add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        // single request from requester 2
        add(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 4'b0100);
        add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000);
        // pointer 3, only requester 1: wrap to unmasked vector
        add(1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000);
        add(1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 2'd3, 4'b0010);
        // reset, then all four requesting with cache always ready
        add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2 & 2'd0, 4'b0000);
        add(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 4'b0001);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 4'b0100);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3, 4'b1000);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 2'd0, 4'b0001);
        add(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010);
        // reset while granting index 2 with the cache ready: no accept reported
        add(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 4'b0000);
        add(1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 4'b0100);
        // same requester re-requests: one IDLE cycle in between
        add(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000);
        add(1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 2'd3, 4'b0100);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst_n     = vecs[k].rst_n;
            req_valid = vecs[k].req;
            gnt_ready = vecs[k].rdy;
            #1;
            obs($sformatf("vec%0d", k), vecs[k].valid, vecs[k].idx, vecs[k].chk_idx,
                vecs[k].ptr, vecs[k].ready);
        end

        // stall: grant 0 held while the cache is not ready, pointer frozen
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        gnt_ready = 1'b0;
        #1;
        obs("stall.pre", 1'b0, 2'd0, 1'b1, 2'd0, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            obs($sformatf("stall.c%0d", c), 1'b1, 2'd0, 1'b1, 2'd0, 4'b0000);
        end
        @(negedge clk);
        gnt_ready = 1'b1;
        #1;
        obs("stall.accept", 1'b1, 2'd0, 1'b1, 2'd0, 4'b0001);
        @(negedge clk);
        #1;
        obs("stall.next", 1'b1, 2'd1, 1'b1, 2'd1, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        obs("stall.b2b", 1'b1, 2'd0, 1'b1, 2'd2, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0000;
        gnt_ready = 1'b0;
        #1;
        obs("stall.idle", 1'b0, 2'd0, 1'b0, 2'd1, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
